// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA decrypt front end.
package rsa_pkg;

  localparam int WIDTH = 12;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/cipher_block_loader_word_fifo.sv
// word_fifo: small synchronous FIFO with extra-bit wrapping pointers and a zeroed head when empty.
module word_fifo #(
  parameter int WIDTH      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array, cleared on reset so no stale word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/cipher_block_loader.sv
// Packs ciphertext bytes into 12-bit words, queues them for the decrypt stage, holds key/n.
// Optional feature macro RANGE_CHECK_EN: drop words >= n and raise sticky range_err.
module cipher_block_loader
  import rsa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_key,
  input  logic [WIDTH-1:0] cfg_n,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] msgIn,
  output logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] n,
  output logic             range_err
);

  phase_e           r_phase;
  phase_e           w_phase_nxt;
  logic [7:0]       r_lo;
  logic             r_alive;
  logic             r_cfg_err;
  logic [WIDTH-1:0] r_key;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_push;
  logic             w_drop;
  logic             w_idle;
  logic             w_unused;

  assign w_word     = {in_data[3:0], r_lo};
  assign w_unused   = ^in_data[7:4];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_push     = w_in_fire && (r_phase == PH_HI) && !w_drop;
  assign w_idle     = w_empty && (r_phase == PH_LO);

  assign in_ready  = r_alive && !w_full;
  assign out_valid = !w_empty;
  assign msgIn     = w_head;
  assign key       = r_key;
  assign n         = r_n;
  assign cfg_err   = r_cfg_err;

`ifdef RANGE_CHECK_EN
  logic r_range_err;
  assign w_drop    = (w_word >= r_n);
  assign range_err = r_range_err;

  // Sticky flag for any word rejected by the modulus compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_range_err <= 1'b0;
    end else if (w_in_fire && (r_phase == PH_HI) && w_drop) begin
      r_range_err <= 1'b1;
    end
  end
`else
  assign w_drop    = 1'b0;
  assign range_err = 1'b0;
`endif

  // Packer phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= PH_LO;
    else        r_phase <= w_phase_nxt;
  end

  // Packer next-state: every accepted byte toggles the phase.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_LO:   if (w_in_fire) w_phase_nxt = PH_HI; else w_phase_nxt = PH_LO;
      PH_HI:   if (w_in_fire) w_phase_nxt = PH_LO; else w_phase_nxt = PH_HI;
      default: w_phase_nxt = PH_LO;
    endcase
  end

  // Low byte capture and post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo    <= 8'h00;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_in_fire && (r_phase == PH_LO)) r_lo <= in_data;
    end
  end

  // Key/modulus load only while nothing is queued or half-packed; otherwise flag the attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_n       <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_idle;
      if (cfg_we && w_idle) begin
        r_key <= cfg_key;
        r_n   <= cfg_n;
      end
    end
  end

  word_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_out_fire),
    .i_din   (w_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_cipher_block_loader.sv
// Self-checking bench for cipher_block_loader: vector table, directed corner sequences, random run.
module tb_cipher_block_loader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [11:0] cfg_key;
  logic [11:0] cfg_n;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] msgIn;
  logic [11:0] key;
  logic [11:0] n;
  logic        range_err;

  cipher_block_loader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_key   (cfg_key),
    .cfg_n     (cfg_n),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msgIn     (msgIn),
    .key       (key),
    .n         (n),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: byte stream -> words, queue of pending words, config registers.
  logic [11:0] mq[$];
  logic [11:0] delivered[$];
  bit          m_phase;
  logic [7:0]  m_lo;
  logic [11:0] m_key, m_n;
  bit          m_cfg_err, m_range_err, m_alive;
  int          m_max;
  bit          last_in_fire, last_out_fire;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] exp_word;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 1'b0; m_lo = 8'h00; m_key = 12'h000; m_n = 12'h000;
    m_cfg_err = 1'b0; m_range_err = 1'b0; m_alive = 1'b0; m_max = 0;
  endtask

  // One clock: drive, check every output against the model at negedge, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                      input logic cw, input logic [11:0] ck, input logic [11:0] cn);
    logic [11:0] w;
    in_valid = v; in_data = d; out_ready = ordy; cfg_we = cw; cfg_key = ck; cfg_n = cn;
    @(negedge clk);
    check("out_valid", out_valid, mq.size() > 0);
    check("msgIn", msgIn, (mq.size() > 0) ? mq[0] : 12'h000);
    check("in_ready", in_ready, m_alive && (mq.size() < DEPTH));
    check("key", key, m_key);
    check("n", n, m_n);
    check("cfg_err", cfg_err, m_cfg_err);
    check("range_err", range_err, m_range_err);
    last_in_fire  = v && in_ready;
    last_out_fire = out_valid && ordy;
    m_cfg_err = 1'b0;
    if (cw) begin
      if (mq.size() == 0 && !m_phase) begin
        m_key = ck; m_n = cn;
      end else begin
        m_cfg_err = 1'b1;
      end
    end
    if (last_out_fire && mq.size() > 0) begin
      delivered.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (last_in_fire) begin
      if (!m_phase) begin
        m_lo = d; m_phase = 1'b1;
      end else begin
        w = {d[3:0], m_lo};
        m_phase = 1'b0;
`ifdef RANGE_CHECK_EN
        if (w >= m_n) m_range_err = 1'b1;
        else          mq.push_back(w);
`else
        mq.push_back(w);
`endif
      end
    end
    m_alive = 1'b1;
    if (mq.size() > m_max) m_max = mq.size();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, ordy, 1'b0, 12'h000, 12'h000);
  endtask

  task automatic config_regs(input logic [11:0] ck, input logic [11:0] cn);
    step(1'b0, 8'h00, 1'b0, 1'b1, ck, cn);
  endtask

  task automatic byte_in(input logic [7:0] d, input logic ordy);
    step(1'b1, d, ordy, 1'b0, 12'h000, 12'h000);
  endtask

  logic [7:0]  t2_bytes[10];
  logic [11:0] t2_words[$];
  logic [11:0] t5_exp[$];
  int idx;
  int pops;
  int cnt;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 12'h000};
    vecs[1] = '{8'hFE, 8'hAF, 12'hFFE};
    vecs[2] = '{8'h34, 8'hF2, 12'h234};
    vecs[3] = '{8'h2C, 8'h01, 12'h12C};
    vecs[4] = '{8'h80, 8'h57, 12'h780};
    vecs[5] = '{8'h01, 8'h10, 12'h001};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_key = 12'h000; cfg_n = 12'h000;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_msgIn", msgIn, 12'h000);
    check("rst_key_n", {key, n}, 24'h000000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);
    check("ready_after_release", in_ready, 1'b1);

    // Basic packing: 0x2C, 0x01 -> 300.
    config_regs(12'd103, 12'd143);
    byte_in(8'h2C, 1'b0);
    byte_in(8'h01, 1'b0);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_msgIn", msgIn, 12'd300);
    check("t1_key", key, 12'd103);
    check("t1_n", n, 12'd143);
    idle(1'b0);
    check("t1_hold", msgIn, 12'd300);
    idle(1'b1);
    idle(1'b0);

    // Vector table with a wide modulus.
    config_regs(12'd103, 12'hFFF);
    for (int i = 0; i < 6; i++) begin
      byte_in(vecs[i].lo, 1'b0);
      byte_in(vecs[i].hi, 1'b0);
      check("vec_valid", out_valid, 1'b1);
      check("vec_word", msgIn, vecs[i].exp_word);
      idle(1'b1);
    end
    idle(1'b0);

    // Config attempt while a word is half packed.
    byte_in(8'h05, 1'b0);
    config_regs(12'd7, 12'd9);
    check("t3_cfg_err", cfg_err, 1'b1);
    check("t3_key", key, 12'd103);
    check("t3_n", n, 12'hFFF);
    byte_in(8'h00, 1'b0);
    check("t3_word", msgIn, 12'h005);
    idle(1'b1);
    idle(1'b0);

    // Range handling with n = 143.
    config_regs(12'd103, 12'd143);
    delivered.delete();
    byte_in(8'h8E, 1'b1); byte_in(8'h00, 1'b1);
    byte_in(8'h8F, 1'b1); byte_in(8'h00, 1'b1);
    byte_in(8'hFF, 1'b1); byte_in(8'h0F, 1'b1);
    idle(1'b1); idle(1'b1);
`ifdef RANGE_CHECK_EN
    t5_exp = '{12'd142};
    check("t5_range_err", range_err, 1'b1);
`else
    t5_exp = '{12'd142, 12'd143, 12'hFFF};
    check("t5_range_err", range_err, 1'b0);
`endif
    check("t5_count", delivered.size(), t5_exp.size());
    for (int i = 0; i < t5_exp.size() && i < delivered.size(); i++)
      check("t5_word", delivered[i], t5_exp[i]);

    // Back-pressure: 10 bytes with the consumer stalled.
    for (int i = 0; i < 10; i++) t2_bytes[i] = (i % 2 == 0) ? 8'(8'h11 * (i / 2 + 1)) : 8'hA0;
    t2_words.delete();
    for (int i = 0; i < 5; i++) t2_words.push_back({4'h0, t2_bytes[2 * i]});
    delivered.delete();
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      step(idx < 10, t2_bytes[idx % 10], 1'b0, 1'b0, 12'h000, 12'h000);
      if (last_in_fire) idx++;
    end
    check("t2_accepted_when_full", idx, 8);
    check("t2_in_ready_full", in_ready, 1'b0);
    cnt = 0;
    while ((idx < 10 || mq.size() > 0) && cnt < 60) begin
      step(idx < 10, t2_bytes[idx % 10], 1'b1, 1'b0, 12'h000, 12'h000);
      if (last_in_fire) idx++;
      cnt++;
    end
    check("t2_drain_timeout", cnt < 60, 1'b1);
    check("t2_count", delivered.size(), 5);
    for (int i = 0; i < 5 && i < delivered.size(); i++) check("t2_order", delivered[i], t2_words[i]);

    // Asynchronous reset with a word queued.
    byte_in(8'h3C, 1'b0);
    byte_in(8'h02, 1'b0);
    check("t4_queued", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_out_valid", out_valid, 1'b0);
    check("t4_msgIn", msgIn, 12'h000);
    check("t4_in_ready", in_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);

    // Streaming throughput with the consumer always ready.
    config_regs(12'd103, 12'hFFF);
    m_max = 0; pops = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 8'($urandom_range(0, 255)) & 8'hF7, 1'b1, 1'b0, 12'h000, 12'h000);
      if (last_out_fire) pops++;
    end
    check("t6_rate", pops >= 9, 1'b1);
    check("t6_max_count", m_max <= 1, 1'b1);
    idle(1'b1); idle(1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
